ball_rally_engine: RTL and testbench

- Parametrised successor to the two-board pong ball controller.
- Owns ball position, vertical velocity, gravity phase and speed level for one half of a split field.
- Serves locally, bounces off top and bottom walls, and reverses on paddle collision.
- Hands the ball to the remote board with a valid/ready packet, and accepts incoming balls the same way. Sits between the paddle/collision logic and the inter-board link bridge.

---
 rtl/ball_rally_engine.sv | 217 +++++++++++++++++++++
 tb/tb_ball_rally_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_rally_engine.sv
// ball_rally_engine: split-field ball serve/bounce/handoff engine; HANDOFF_TIMEOUT_EN adds a TX timeout
module ball_rally_engine #(
  parameter int FIELD_W = 640,
  parameter int FIELD_H = 480,
  parameter int BALL_SIZE = 20,
  parameter int X_STEP = 10,
  parameter int GRAV_PERIOD = 4,
  parameter int BASE_TICKS = 270000,
  parameter int SERVE_Y = 220,
  parameter int VY_INIT = -3,
  parameter int VY_W = 8,
  parameter int SCORE_W = 4
`ifdef HANDOFF_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2500000
`endif
) (
  input  logic                             clk_25MHZ,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             collision,
  input  logic [9:0]                       paddle_speed,
  output logic [9:0]                       ball_x,
  output logic [9:0]                       ball_y,
  output logic                             ball_dir,
  output logic                             game_over,
  output logic [SCORE_W-1:0]               miss_count,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [9:0]                       tx_y,
  output logic signed [VY_W-1:0]           tx_vy,
  output logic [$clog2(GRAV_PERIOD)-1:0]   tx_grav,
  output logic [1:0]                       tx_lvl,
  input  logic                             rx_valid,
  output logic                             rx_ready,
  input  logic [9:0]                       rx_y,
  input  logic signed [VY_W-1:0]           rx_vy,
  input  logic [$clog2(GRAV_PERIOD)-1:0]   rx_grav,
  input  logic [1:0]                       rx_lvl
);
  localparam int GW = $clog2(GRAV_PERIOD);
  localparam int TW = $clog2(BASE_TICKS + 1);
  localparam logic signed [VY_W-1:0] VPOS = VY_W'(2 ** (VY_W - 1) - 1);
  localparam logic signed [VY_W:0] VMAX = {1'b0, VPOS};
  localparam logic signed [10:0] YMAX = 11'(FIELD_H - 1);
  localparam logic [9:0] X_EDGE = 10'(FIELD_W - BALL_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, TX, OVER} state_t;
  state_t st, st_nx;

  logic signed [VY_W-1:0] vy, vy_nx, vy_s, vy_neg;
  logic signed [VY_W:0] vy_inc;
  logic signed [10:0] y_s;
  logic [GW-1:0] grav, grav_nx, grav_s;
  logic [1:0] lvl, lvl_nx, spd_lvl, txl_nx;
  logic [TW-1:0] tick, tick_nx, per_raw, tick_last;
  logic [9:0] x_nx, y_nx, txy_nx;
  logic signed [VY_W-1:0] txvy_nx;
  logic [GW-1:0] txg_nx;
  logic [SCORE_W-1:0] miss_nx, miss_inc;
  logic dir_nx, txv_nx, wrap, hi, lo;
`ifdef HANDOFF_TIMEOUT_EN
  localparam int MW = $clog2(TIMEOUT_CYCLES + 1);
  logic [MW-1:0] tmo, tmo_nx;
`endif

  assign game_over = st == OVER;
  assign rx_ready  = st == IDLE || st == OVER;
  // Fast levels may shift the period to zero; treat that as one step per cycle.
  assign per_raw   = TW'(BASE_TICKS) >> lvl;
  assign tick_last = per_raw == '0 ? '0 : per_raw - TW'(1);
  assign spd_lvl   = paddle_speed < 10'd2 ? 2'd0 : paddle_speed < 10'd4 ? 2'd1 :
                     paddle_speed < 10'd8 ? 2'd2 : 2'd3;
  assign miss_inc  = &miss_count ? miss_count : miss_count + SCORE_W'(1);
  assign wrap      = grav == GW'(GRAV_PERIOD - 1);
  assign grav_s    = wrap ? '0 : grav + GW'(1);
  assign vy_inc    = {vy[VY_W-1], vy} + {{VY_W{1'b0}}, wrap};
  assign vy_s      = vy_inc > VMAX ? VPOS : vy_inc < -VMAX ? -VPOS : vy_inc[VY_W-1:0];
  assign vy_neg    = -vy_s;
  assign y_s       = $signed({1'b0, ball_y}) + 11'(vy);
  assign hi        = y_s >= YMAX;
  assign lo        = y_s <= 11'sd0;

  always_comb begin
    st_nx = st;
    x_nx = ball_x;
    y_nx = ball_y;
    vy_nx = vy;
    grav_nx = grav;
    lvl_nx = lvl;
    tick_nx = tick;
    dir_nx = ball_dir;
    miss_nx = miss_count;
    txv_nx = tx_valid;
    txy_nx = tx_y;
    txvy_nx = tx_vy;
    txg_nx = tx_grav;
    txl_nx = tx_lvl;
`ifdef HANDOFF_TIMEOUT_EN
    tmo_nx = tmo;
`endif
    case (st)
      IDLE, OVER: begin
        if (rx_valid) begin
          st_nx = RUN;
          x_nx = X_EDGE;
          y_nx = rx_y;
          vy_nx = rx_vy;
          grav_nx = rx_grav;
          lvl_nx = rx_lvl;
          dir_nx = 1'b0;
          tick_nx = '0;
        end else if (start) begin
          st_nx = RUN;
          x_nx = '0;
          y_nx = 10'(SERVE_Y);
          vy_nx = VY_W'(VY_INIT);
          grav_nx = '0;
          lvl_nx = '0;
          dir_nx = 1'b1;
          tick_nx = '0;
        end
      end
      RUN: begin
        if (collision && !ball_dir) begin
          dir_nx = 1'b1;
          tick_nx = '0;
          lvl_nx = spd_lvl;
        end else if (ball_dir && ball_x >= X_EDGE) begin
          st_nx = TX;
          txv_nx = 1'b1;
          txy_nx = ball_y;
          txvy_nx = vy;
          txg_nx = grav;
          txl_nx = lvl;
`ifdef HANDOFF_TIMEOUT_EN
          tmo_nx = '0;
`endif
        end else if (tick == tick_last) begin
          tick_nx = '0;
          if (!ball_dir && ball_x < 10'(X_STEP)) begin
            st_nx = OVER;
            x_nx = '0;
            y_nx = 10'(SERVE_Y);
            miss_nx = miss_inc;
          end else begin
            x_nx = ball_dir ? ball_x + 10'(X_STEP) : ball_x - 10'(X_STEP);
            grav_nx = grav_s;
            y_nx = hi ? 10'(FIELD_H - 1) : lo ? '0 : y_s[9:0];
            vy_nx = (hi || lo) ? vy_neg : vy_s;
          end
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      TX: begin
        if (tx_ready) begin
          st_nx = IDLE;
          txv_nx = 1'b0;
          x_nx = '0;
          y_nx = 10'(SERVE_Y);
        end
`ifdef HANDOFF_TIMEOUT_EN
        else if (tmo == MW'(TIMEOUT_CYCLES - 1)) begin
          st_nx = OVER;
          txv_nx = 1'b0;
          x_nx = '0;
          y_nx = 10'(SERVE_Y);
          miss_nx = miss_inc;
        end else begin
          tmo_nx = tmo + MW'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      ball_x <= '0;
      ball_y <= 10'(SERVE_Y);
      vy <= VY_W'(VY_INIT);
      grav <= '0;
      lvl <= '0;
      tick <= '0;
      ball_dir <= 1'b1;
      miss_count <= '0;
      tx_valid <= 1'b0;
      tx_y <= '0;
      tx_vy <= '0;
      tx_grav <= '0;
      tx_lvl <= '0;
`ifdef HANDOFF_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      st <= st_nx;
      ball_x <= x_nx;
      ball_y <= y_nx;
      vy <= vy_nx;
      grav <= grav_nx;
      lvl <= lvl_nx;
      tick <= tick_nx;
      ball_dir <= dir_nx;
      miss_count <= miss_nx;
      tx_valid <= txv_nx;
      tx_y <= txy_nx;
      tx_vy <= txvy_nx;
      tx_grav <= txg_nx;
      tx_lvl <= txl_nx;
`ifdef HANDOFF_TIMEOUT_EN
      tmo <= tmo_nx;
`endif
    end
  end
endmodule

// File: tb/tb_ball_rally_engine.sv
// tb_ball_rally_engine: directed tables plus randomized run against a behavioural model
module tb_ball_rally_engine;
  localparam int BT = 4, FW = 100, FH = 480, BS = 20, XS = 10, GP = 4, SY = 220, VI = -3;
  localparam int M_IDLE = 0, M_RUN = 1, M_TX = 2, M_OVER = 3;

  logic clk_25MHZ = 1'b0, reset_n = 1'b1, start = 1'b0, collision = 1'b0;
  logic tx_ready = 1'b0, rx_valid = 1'b0;
  logic [9:0] paddle_speed = '0, rx_y = '0;
  logic signed [7:0] rx_vy = '0;
  logic [1:0] rx_grav = '0, rx_lvl = '0;
  logic [9:0] ball_x, ball_y, tx_y;
  logic ball_dir, game_over, tx_valid, rx_ready;
  logic [3:0] miss_count;
  logic signed [7:0] tx_vy;
  logic [1:0] tx_grav, tx_lvl;

  ball_rally_engine #(.FIELD_W(FW), .FIELD_H(FH), .BALL_SIZE(BS), .X_STEP(XS),
                      .GRAV_PERIOD(GP), .BASE_TICKS(BT), .SERVE_Y(SY), .VY_INIT(VI)) dut (
    .clk_25MHZ(clk_25MHZ), .reset_n(reset_n), .start(start), .collision(collision),
    .paddle_speed(paddle_speed), .ball_x(ball_x), .ball_y(ball_y), .ball_dir(ball_dir),
    .game_over(game_over), .miss_count(miss_count), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_y(tx_y), .tx_vy(tx_vy), .tx_grav(tx_grav), .tx_lvl(tx_lvl), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_y(rx_y), .rx_vy(rx_vy), .rx_grav(rx_grav), .rx_lvl(rx_lvl));

  always #5 clk_25MHZ = ~clk_25MHZ;

  int n_chk = 0, n_fail = 0;
  typedef struct {bit st; int x; int y;} srow_t;
  typedef struct {int ps; int lvl;} lrow_t;
  srow_t serve_tbl[17];
  lrow_t lvl_tbl[8];

  int mst, mx, my, mvy, mgrav, mlvl, mleft, mdir, mmiss, mtxv, mtxy, mtxvy, mtxg, mtxl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_25MHZ);
      #1;
    end
  endtask

  function automatic logic [27:0] obs();
    return {ball_x, ball_y, ball_dir, game_over, miss_count, tx_valid, rx_ready};
  endfunction

  function automatic logic [27:0] mk(int x, int y, int dir, int go, int miss, int txv, int rxr);
    return {10'(x), 10'(y), 1'(dir), 1'(go), 4'(miss), 1'(txv), 1'(rxr)};
  endfunction

  function automatic logic [21:0] txf(int y, int vy, int g, int l);
    return {10'(y), 8'(vy), 2'(g), 2'(l)};
  endfunction

  function automatic int per(int l);
    return (BT >> l) > 0 ? (BT >> l) : 1;
  endfunction

  function automatic int speed_level(int ps);
    int l = $clog2(ps + 1) - 1;
    return l < 0 ? 0 : (l > 3 ? 3 : l);
  endfunction

  task automatic model_reset();
    mst = M_IDLE; mx = 0; my = SY; mvy = VI; mgrav = 0; mlvl = 0; mleft = per(0);
    mdir = 1; mmiss = 0; mtxv = 0; mtxy = 0; mtxvy = 0; mtxg = 0; mtxl = 0;
  endtask

  task automatic model_step();
    int vn, ys;
    if (mst == M_IDLE || mst == M_OVER) begin
      if (rx_valid) begin
        mst = M_RUN; mx = FW - BS; my = int'(rx_y); mvy = int'(rx_vy);
        mgrav = int'(rx_grav); mlvl = int'(rx_lvl); mdir = 0; mleft = per(mlvl);
      end else if (start) begin
        mst = M_RUN; mx = 0; my = SY; mvy = VI; mgrav = 0; mlvl = 0; mdir = 1; mleft = per(0);
      end
    end else if (mst == M_RUN) begin
      if (collision && mdir == 0) begin
        mdir = 1; mlvl = speed_level(int'(paddle_speed)); mleft = per(mlvl);
      end else if (mdir == 1 && mx >= FW - BS) begin
        mst = M_TX; mtxv = 1; mtxy = my; mtxvy = mvy; mtxg = mgrav; mtxl = mlvl;
      end else if (mleft == 1) begin
        mleft = per(mlvl);
        if (mdir == 0 && mx < XS) begin
          mst = M_OVER; mx = 0; my = SY; mmiss = mmiss < 15 ? mmiss + 1 : 15;
        end else begin
          mx = mdir ? mx + XS : mx - XS;
          vn = mvy + (mgrav == GP - 1 ? 1 : 0);
          vn = vn > 127 ? 127 : (vn < -127 ? -127 : vn);
          mgrav = (mgrav + 1) % GP;
          ys = my + mvy;
          if (ys >= FH - 1) begin my = FH - 1; mvy = -vn; end
          else if (ys <= 0) begin my = 0; mvy = -vn; end
          else begin my = ys; mvy = vn; end
        end
      end else begin
        mleft--;
      end
    end else if (tx_ready) begin
      mst = M_IDLE; mtxv = 0; mx = 0; my = SY;
    end
  endtask

  task automatic rx_load(input int y, input int vy, input int g, input int l);
    rx_valid = 1'b1; rx_y = 10'(y); rx_vy = 8'(vy); rx_grav = 2'(g); rx_lvl = 2'(l);
    cyc();
    rx_valid = 1'b0;
  endtask

  initial begin
    int ys[5] = '{220, 217, 214, 211, 208};
    bit bad;
    for (int i = 0; i < 17; i++) serve_tbl[i] = '{i == 0, (i / 4) * XS, ys[i / 4]};
    lvl_tbl = '{'{0, 0}, '{1, 0}, '{2, 1}, '{3, 1}, '{4, 2}, '{7, 2}, '{8, 3}, '{1023, 3}};

    #2 reset_n = 1'b0;
    cyc(3);
    chk("reset_state", obs(), mk(0, SY, 1, 0, 0, 0, 1));
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      start = serve_tbl[i].st;
      cyc();
      chk($sformatf("serve_%0d", i), obs(), mk(serve_tbl[i].x, serve_tbl[i].y, 1, 0, 0, 0, 0));
    end
    start = 1'b0;
    cyc(16);
    chk("serve_x80", obs(), mk(80, 200, 1, 0, 0, 0, 0));
    cyc();
    chk("handoff_enter", obs(), mk(80, 200, 1, 0, 0, 1, 0));
    chk("handoff_fields", {tx_y, tx_vy, tx_grav, tx_lvl}, txf(200, -1, 0, 0));
    start = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (obs() !== mk(80, 200, 1, 0, 0, 1, 0) || {tx_y, tx_vy, tx_grav, tx_lvl} !== txf(200, -1, 0, 0))
        bad = 1'b1;
    end
    chk("tx_hold_stable", 64'(bad), 64'(0));
    start = 1'b0;
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("tx_done", obs(), mk(0, SY, 1, 0, 0, 0, 1));
    cyc(3);
    chk("tx_single", obs(), mk(0, SY, 1, 0, 0, 0, 1));

    rx_load(2, -3, 0, 0);
    chk("rx_load", obs(), mk(80, 2, 0, 0, 0, 0, 0));
    cyc(4);
    chk("wall_bounce", obs(), mk(70, 0, 0, 0, 0, 0, 0));
    cyc(4);
    chk("wall_after", obs(), mk(60, 3, 0, 0, 0, 0, 0));
    cyc(8);
    chk("pre_paddle", obs(), mk(40, 9, 0, 0, 0, 0, 0));
    collision = 1'b1;
    paddle_speed = 10'd5;
    cyc();
    collision = 1'b0;
    chk("paddle_hit", obs(), mk(40, 9, 1, 0, 0, 0, 0));
    cyc();
    chk("fast_step1", obs(), mk(50, 13, 1, 0, 0, 0, 0));
    cyc();
    chk("fast_step2", obs(), mk(60, 17, 1, 0, 0, 0, 0));
    cyc(3);
    chk("fast_handoff", obs(), mk(80, 25, 1, 0, 0, 1, 0));
    chk("fast_fields", {tx_y, tx_vy, tx_grav, tx_lvl}, txf(25, 5, 0, 2));
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;

    foreach (lvl_tbl[i]) begin
      rx_load(100, 5, 1, 0);
      collision = 1'b1;
      paddle_speed = 10'(lvl_tbl[i].ps);
      cyc();
      collision = 1'b0;
      cyc();
      chk($sformatf("lvl_ps%0d", lvl_tbl[i].ps), {tx_valid, tx_y, tx_vy, tx_grav, tx_lvl},
          {1'b1, txf(100, 5, 1, lvl_tbl[i].lvl)});
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
    end

    rx_load(100, 0, 0, 3);
    cyc(8);
    chk("miss_x0", obs(), mk(0, 104, 0, 0, 0, 0, 0));
    cyc();
    chk("miss_over", obs(), mk(0, SY, 0, 1, 1, 0, 1));
    start = 1'b1;
    rx_load(30, 2, 1, 1);
    start = 1'b0;
    chk("rx_beats_start", obs(), mk(80, 30, 0, 0, 1, 0, 0));
    collision = 1'b1;
    paddle_speed = 10'd0;
    cyc();
    collision = 1'b0;
    cyc();
    chk("tx_before_reset", obs(), mk(80, 30, 1, 0, 1, 1, 0));
    #3 reset_n = 1'b0;
    #1 chk("reset_async", obs(), mk(0, SY, 1, 0, 0, 0, 1));
    cyc();
    reset_n = 1'b1;

    model_reset();
    for (int i = 0; i < 6000; i++) begin
      start = $urandom_range(0, 15) == 0;
      collision = $urandom_range(0, 19) == 0;
      paddle_speed = 10'($urandom_range(0, 20));
      tx_ready = $urandom_range(0, 2) == 0;
      rx_valid = $urandom_range(0, 3) == 0;
      rx_y = 10'($urandom_range(0, FH - 1));
      rx_vy = 8'($urandom);
      rx_grav = 2'($urandom);
      rx_lvl = 2'($urandom);
      model_step();
      cyc();
      chk("rand_obs", obs(), mk(mx, my, mdir, mst == M_OVER, mmiss, mtxv, mst == M_IDLE || mst == M_OVER));
      if (mtxv != 0) chk("rand_tx", {tx_y, tx_vy, tx_grav, tx_lvl}, txf(mtxy, mtxvy, mtxg, mtxl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
